// File: rtl/fp_addsub_sequencer_if.sv
// Signal bundle linking fp_addsub_sequencer to its request source, its result
// consumer and the fp_add_sub datapath (num1/num2/op out, S back in).
interface fp_addsub_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [1:0]  op;
    logic [31:0] S;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_flags;
    logic        busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, S, res_ready,
        output req_ready, num1, num2, op, res_valid, res_data, res_flags, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, S, res_ready,
        input  req_ready, num1, num2, op, res_valid, res_data, res_flags, busy
    );
endinterface

// File: rtl/fp_addsub_sequencer.sv
// Request FIFO and result collector for fp_add_sub: issues one queued operand
// set at a time, waits ADD_LAT cycles, captures S and classifies it.
module fp_addsub_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input logic                  clk,
    input logic                  rst,
    fp_addsub_sequencer_if.slave bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam int unsigned LAST     = ADD_LAT - 1;
    localparam int unsigned DEPTH_CT = DEPTH;
    localparam logic [AW:0]   FULL_CNT = DEPTH_CT[AW:0];
    localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [65:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          s_nan;
    logic          s_inf;
    logic          s_zero;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = bus.req_valid & ~full;
    assign pop   = (state == IDLE) & ~empty;

    assign bus.req_ready = ~full;
    assign bus.busy      = ~empty | (state != IDLE);
    assign bus.res_valid = (state == DONE);

    assign s_nan  = (bus.S[30:23] == 8'hFF) & (bus.S[22:0] != '0);
    assign s_inf  = (bus.S[30:23] == 8'hFF) & (bus.S[22:0] == '0);
    assign s_zero = (bus.S[30:0] == '0);

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.req_op, bus.req_a, bus.req_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.num1      <= '0;
            bus.num2      <= '0;
            bus.op        <= '0;
            bus.res_data  <= '0;
            bus.res_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {bus.op, bus.num1, bus.num2} <= mem[rd_ptr];
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        bus.res_data  <= bus.S;
                        bus.res_flags <= {s_nan, s_inf, s_zero};
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Randomised bench for fp_addsub_sequencer against a transaction-level model,
// with a stub fp_add_sub producing S from the issued operands.
module tb_fp_addsub_sequencer;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ADD_LAT = 2;
    localparam int          QD      = DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fp_addsub_sequencer_if bus();

    fp_addsub_sequencer #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- fp32 arithmetic via real ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else        repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [31:0] x);
        real mag;
        int  e;
        e = int'(x[30:23]);
        if (e == 0) mag = real'(x[22:0]) * pow2(-149);
        else        mag = real'({1'b1, x[22:0]}) * pow2(e - 150);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] to_bits(input real r);
        logic [63:0] d;
        logic [23:0] m;
        logic [31:0] mag;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0)   return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        m = {1'b0, d[51:29]};
        if (d[28] && ((d[27:0] != '0) || d[29])) m = m + 24'd1;
        mag = (32'(e) << 23) + {8'd0, m};
        if (mag[30:23] == 8'hFF) return {d[63], 8'hFF, 23'd0};
        return {d[63], mag[30:0]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        return o[0] ? to_bits(to_real(a) - to_real(b)) : to_bits(to_real(a) + to_real(b));
    endfunction

    function automatic logic [2:0] classify(input logic [31:0] x);
        return {(x[30:23] == 8'hFF) && (x[22:0] != '0),
                (x[30:23] == 8'hFF) && (x[22:0] == '0),
                (x[30:0] == '0)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'($urandom_range(135, 120));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    // ---------------- stub fp_add_sub ----------------
    logic        force_en  = 1'b0;
    logic [31:0] force_val = '0;
    logic [31:0] spipe [ADD_LAT-1];

    always @(posedge clk) begin
        spipe[0] <= fp_op(bus.num1, bus.num2, bus.op);
        for (int i = 1; i < ADD_LAT - 1; i++) spipe[i] <= spipe[i-1];
    end
    assign bus.S = force_en ? force_val : spipe[ADD_LAT-2];

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } req_t;

    req_t        mq[$];
    logic [31:0] exp_q[$];
    req_t        cur = '{32'd0, 32'd0, 2'd0};
    req_t        inreq;
    int          m_phase = 0;   // 0: nothing issued, 1: adder computing, 2: result held
    int          m_left  = 0;
    logic [31:0] m_res   = '0;
    logic [2:0]  m_flags = '0;
    int          n_results = 0;
    logic        accept;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            cur     = '{32'd0, 32'd0, 2'd0};
            m_phase = 0;
            m_left  = 0;
            m_res   = '0;
            m_flags = '0;
        end else begin
            accept = bus.req_valid && (mq.size() < QD);
            inreq  = '{bus.req_a, bus.req_b, bus.req_op};
            if (bus.res_valid && bus.res_ready) begin
                n_results++;
                if (exp_q.size() == 0) check1("spurious_result", 1'b1, 1'b0);
                else check32("result_order", bus.res_data, exp_q.pop_front());
            end
            case (m_phase)
                0: if (mq.size() > 0) begin
                    cur     = mq.pop_front();
                    m_phase = 1;
                    m_left  = ADD_LAT;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_res   = force_en ? force_val : fp_op(cur.a, cur.b, cur.op);
                        m_flags = classify(m_res);
                        m_phase = 2;
                    end
                end
                default: if (bus.res_ready) m_phase = 0;
            endcase
            if (accept) begin
                mq.push_back(inreq);
                exp_q.push_back(force_en ? force_val : fp_op(inreq.a, inreq.b, inreq.op));
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check1("req_ready", bus.req_ready, mq.size() < QD);
            check1("busy", bus.busy, (mq.size() != 0) || (m_phase != 0));
            check1("res_valid", bus.res_valid, m_phase == 2);
            check32("num1", bus.num1, cur.a);
            check32("num2", bus.num2, cur.b);
            check32("op", {30'd0, bus.op}, {30'd0, cur.op});
            check32("res_data", bus.res_data, m_res);
            check32("res_flags", {29'd0, bus.res_flags}, {29'd0, m_flags});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = o;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("push_timeout", n < 100, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check1("idle_timeout", n < 300, 1'b1);
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("res_timeout", n < 100, 1'b1);
    endtask

    logic [31:0] flag_vals [4] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001};
    logic [2:0]  flag_exp  [4] = '{3'b100, 3'b010, 3'b001, 3'b000};

    initial begin
        int          n;
        int          base;
        logic [31:0] held_data;
        logic [31:0] held_num1;
        logic [2:0]  held_flags;

        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;

        // model pins
        check32("pin_add", fp_op(32'h3F8E147B, 32'h3F8147AE, 2'd0), 32'h4007AE14);
        check32("pin_sub", fp_op(32'h40400000, 32'h3F800000, 2'd1), 32'h40000000);
        for (int i = 0; i < 4; i++)
            check32("pin_class", {29'd0, classify(flag_vals[i])}, {29'd0, flag_exp[i]});

        #2 rst = 1'b1;
        #1;
        chk_en = 1'b1;
        check1("rst_res_valid", bus.res_valid, 1'b0);
        check1("rst_req_ready", bus.req_ready, 1'b1);
        check1("rst_busy", bus.busy, 1'b0);
        check32("rst_num1", bus.num1, 32'd0);
        check32("rst_res_data", bus.res_data, 32'd0);
        check32("rst_flags", {29'd0, bus.res_flags}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1: single add, latency counted in edges including the accept edge
        bus.res_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_a     = 32'h3F8E147B;
        bus.req_b     = 32'h3F8147AE;
        bus.req_op    = 2'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_res(n);
        check32("t1_latency", n + 1, ADD_LAT + 2);
        check32("t1_data", bus.res_data, 32'h4007AE14);
        check32("t1_flags", {29'd0, bus.res_flags}, 32'd0);
        wait_idle();
        check1("t1_busy_low", bus.busy, 1'b0);

        // T2: fill with result stalled
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rand_fp(), rand_fp(), 2'($urandom_range(3, 0)));
        check1("t2_full", bus.req_ready, 1'b0);
        base = n_results;
        bus.res_ready = 1'b1;
        wait_idle();
        check32("t2_count", n_results - base, 5);

        // T3: hold result under backpressure
        bus.res_ready = 1'b0;
        push(rand_fp(), rand_fp(), 2'd1);
        wait_res(n);
        held_data  = bus.res_data;
        held_flags = bus.res_flags;
        held_num1  = bus.num1;
        base       = n_results;
        repeat (10) begin
            @(negedge clk);
            check1("t3_valid", bus.res_valid, 1'b1);
            check32("t3_data", bus.res_data, held_data);
            check32("t3_flags", {29'd0, bus.res_flags}, {29'd0, held_flags});
            check32("t3_num1", bus.num1, held_num1);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        repeat (4) @(negedge clk);
        check32("t3_one_result", n_results - base, 1);
        check1("t3_valid_low", bus.res_valid, 1'b0);

        // T4: forced S classes
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            force_en  = 1'b1;
            force_val = flag_vals[i];
            push(rand_fp(), rand_fp(), 2'd0);
            wait_res(n);
            check32("t4_data", bus.res_data, flag_vals[i]);
            check32("t4_flags", {29'd0, bus.res_flags}, {29'd0, flag_exp[i]});
            wait_idle();
            force_en = 1'b0;
        end

        // T5: push and pop together at fill level 2, then fill to prove count held
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(rand_fp(), rand_fp(), 2'd0);
        wait_res(n);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        push(rand_fp(), rand_fp(), 2'd1);
        check1("t5_simul_ready", bus.req_ready, 1'b1);
        push(rand_fp(), rand_fp(), 2'd0);
        check1("t5_three_ready", bus.req_ready, 1'b1);
        push(rand_fp(), rand_fp(), 2'd0);
        check1("t5_full", bus.req_ready, 1'b0);
        bus.res_ready = 1'b1;
        wait_idle();

        // wrap and random traffic
        base = n_results;
        for (int i = 0; i < 3 * QD; i++) push(rand_fp(), rand_fp(), 2'($urandom_range(3, 0)));
        wait_idle();
        check32("wrap_count", n_results - base, 3 * QD);
        repeat (400) begin
            bus.req_valid = ($urandom_range(1, 0) == 1);
            bus.req_a     = rand_fp();
            bus.req_b     = rand_fp();
            bus.req_op    = 2'($urandom_range(3, 0));
            bus.res_ready = ($urandom_range(9, 0) < 7);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        wait_idle();
        check32("drain_empty", exp_q.size(), 0);

        // T6: reset while an op is in flight with two queued
        for (int i = 0; i < 3; i++) push(rand_fp(), rand_fp(), 2'd0);
        check1("t6_setup", (m_phase == 1) && (mq.size() == 2), 1'b1);
        base = n_results;
        #2 rst = 1'b1;
        #1;
        check1("t6_res_valid", bus.res_valid, 1'b0);
        check1("t6_busy", bus.busy, 1'b0);
        check1("t6_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check1("t6_no_stale", bus.res_valid, 1'b0);
        end
        check32("t6_no_result", n_results - base, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
